// File: rtl/acc_seq_pkg.sv
// -----------------------------------------------------------------------------
// acc_seq_pkg
// Shared definitions for the accumulator/instruction sequencer:
//   - ALU opcode constants (pass A, add, and, not A)
//   - sequencer FSM state encoding
//   - default widths and the packed instruction record width
// -----------------------------------------------------------------------------
package acc_seq_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_OP_W   = 2;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NOT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Instruction record is {load, op, operand}.
  function automatic int unsigned instr_width(int unsigned data_w, int unsigned op_w);
    return data_w + op_w + 1;
  endfunction

  localparam int unsigned DEF_INSTR_W = DEF_DATA_W + DEF_OP_W + 1;

endpackage : acc_seq_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational read of the head entry.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push_i     : write data_i at the tail (ignored when full)
//   data_i     : write data
//   pop_i      : discard the head entry (ignored when empty)
//   data_o     : head entry, valid whenever empty_o is low
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: storage is left unreset; the count guards every read, so clearing
  // it would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/acc_sequencer.sv
// -----------------------------------------------------------------------------
// acc_sequencer
// Buffers {load, op, operand} instructions from a valid/ready port, presents
// registered operands/opcode to an external 4-bit ALU, and captures the ALU
// result and carry into the accumulator.
//   in_valid/in_ready           : instruction handshake (ready = FIFO not full)
//   in_load, in_op, in_operand  : instruction fields
//   alu_a, alu_b, alu_op        : registered ALU inputs
//   alu_result, alu_cout        : ALU outputs, captured at the end of ISSUE
//   acc, carry_flag, zero_flag  : accumulator state
//   busy                        : FSM not idle or instructions pending
//   done                        : one-cycle pulse after each accumulator update
// -----------------------------------------------------------------------------
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned OP_W       = DEF_OP_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_operand,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic [DATA_W-1:0] acc,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              busy,
  output logic              done
);

  localparam int unsigned INSTR_W = instr_width(DATA_W, OP_W);

  logic [INSTR_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty, pop;

  logic               head_load;
  logic [OP_W-1:0]    head_op;
  logic [DATA_W-1:0]  head_operand;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d, acc_q, acc_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic               load_q, load_d, carry_q, carry_d;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .data_i  ({in_load, in_op, in_operand}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_load    = fifo_head[INSTR_W-1];
  assign head_op      = fifo_head[DATA_W +: OP_W];
  assign head_operand = fifo_head[DATA_W-1:0];

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned (which would infer a latch).
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    load_d   = load_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    unique case (state_q)
      // DONE behaves like IDLE for dispatch, which gives back-to-back
      // instructions a 2-cycle cadence.
      ST_IDLE, ST_DONE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          alu_a_d  = acc_q;
          alu_b_d  = head_operand;
          alu_op_d = head_op;
          load_d   = head_load;
          state_d  = ST_ISSUE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (load_q) begin
          acc_d   = alu_b_q;  // immediate bypasses the ALU
          carry_d = 1'b0;
        end else begin
          acc_d   = alu_result;
          carry_d = alu_cout;
        end
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      load_q   <= 1'b0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      load_q   <= load_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign acc        = acc_q;
  assign carry_flag = carry_q;
  assign zero_flag  = (acc_q == '0);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule : acc_sequencer
